component_pass_scheduler: RTL and testbench

//  Slice-level controller for the shared component pipeline (DCT -> DC VLC -> AC VLC).

---
 rtl/component_pass_scheduler.sv | 95 +++++++++
 tb/tb_component_pass_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/component_pass_scheduler.sv
// component_pass_scheduler: runs the Y, Cb and Cr passes of one slice through the shared component pipeline
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   slice_valid/ready       slice command handshake, slice_block_num = luma block count
//   comp_reset_n            held low for one LOAD cycle before each pass
//   comp_block_num/index    block count and component (0=Y,1=Cb,2=Cr) of the current pass
//   comp_flush_done         end-of-pass pulse from the AC VLC, only honoured in RUN
//   slice_done, busy        completion pulse and activity flag
//   timeout_err, err_clear  sticky pass-hang flag and its clear
module component_pass_scheduler #(
  parameter int CHROMA_SHIFT = 1,
  parameter int DRAIN_CYCLES = 8,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        slice_valid,
  output logic        slice_ready,
  input  logic [31:0] slice_block_num,
  output logic        comp_reset_n,
  output logic [31:0] comp_block_num,
  output logic [1:0]  comp_index,
  input  logic        comp_flush_done,
  output logic        slice_done,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clear
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] blk_q, blk_d, cnt_q, cnt_d, comp_block_num_q, comp_block_num_d, chroma_blk;
  logic [1:0]  comp_index_q, comp_index_d;
  logic        slice_ready_q, slice_ready_d, comp_reset_n_q, comp_reset_n_d;
  logic        slice_done_q, slice_done_d, busy_q, busy_d, timeout_err_q, timeout_err_d;
  logic        accept, timeout_hit, drain_end;
  always_comb begin
    accept      = slice_valid & slice_ready_q;
    timeout_hit = state_q == RUN && !comp_flush_done && cnt_q == 32'(DONE_TIMEOUT - 1);
    drain_end   = state_q == DRAIN && cnt_q == 32'(DRAIN_CYCLES - 1);
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (slice_block_num == '0 ? DONE : LOAD) : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = (comp_flush_done || timeout_hit) ? DRAIN : RUN;
      DRAIN:   state_d = drain_end ? (comp_index_q == 2'd2 ? DONE : LOAD) : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // One counter serves both RUN and DRAIN; it restarts on every state change and saturates.
    cnt_d            = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
    blk_d            = accept ? slice_block_num : blk_q;
    comp_index_d     = accept ? 2'd0 : (drain_end && comp_index_q != 2'd2 ? comp_index_q + 2'd1 : comp_index_q);
    chroma_blk       = blk_d >> CHROMA_SHIFT;
    // Block count is latched on entry to LOAD so it is stable from LOAD through DRAIN.
    comp_block_num_d = state_d != LOAD ? comp_block_num_q :
                       comp_index_d == 2'd0 ? blk_d : (chroma_blk == '0 ? 32'd1 : chroma_blk);
    slice_ready_d    = state_d == IDLE;
    comp_reset_n_d   = state_d == RUN || state_d == DRAIN;
    slice_done_d     = state_d == DONE;
    busy_d           = state_d != IDLE;
    timeout_err_d    = timeout_hit | (timeout_err_q & ~err_clear);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      blk_q            <= '0;
      cnt_q            <= '0;
      comp_block_num_q <= '0;
      comp_index_q     <= '0;
      slice_ready_q    <= 1'b0;
      comp_reset_n_q   <= 1'b0;
      slice_done_q     <= 1'b0;
      busy_q           <= 1'b0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      blk_q            <= blk_d;
      cnt_q            <= cnt_d;
      comp_block_num_q <= comp_block_num_d;
      comp_index_q     <= comp_index_d;
      slice_ready_q    <= slice_ready_d;
      comp_reset_n_q   <= comp_reset_n_d;
      slice_done_q     <= slice_done_d;
      busy_q           <= busy_d;
      timeout_err_q    <= timeout_err_d;
    end
  end
  assign slice_ready    = slice_ready_q;
  assign comp_reset_n   = comp_reset_n_q;
  assign comp_block_num = comp_block_num_q;
  assign comp_index     = comp_index_q;
  assign slice_done     = slice_done_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_component_pass_scheduler.sv
// tb_component_pass_scheduler: randomized slice traffic against a pass-level reference model
module tb_component_pass_scheduler;
  localparam int DR = 2, TO = 16, CS = 1;
  logic        clock = 0, reset_n = 0, slice_valid = 0, comp_flush_done = 0, err_clear = 0;
  logic [31:0] slice_block_num = 0;
  logic        slice_ready, comp_reset_n, slice_done, busy, timeout_err;
  logic [31:0] comp_block_num;
  logic [1:0]  comp_index;
  int          n_tests = 0, n_fail = 0;
  logic        exp_err = 0;
  always #5 clock = ~clock;
  component_pass_scheduler #(.CHROMA_SHIFT(CS), .DRAIN_CYCLES(DR), .DONE_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .slice_valid(slice_valid), .slice_ready(slice_ready),
    .slice_block_num(slice_block_num), .comp_reset_n(comp_reset_n), .comp_block_num(comp_block_num),
    .comp_index(comp_index), .comp_flush_done(comp_flush_done), .slice_done(slice_done),
    .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input logic f, input logic c, input logic s);
    comp_flush_done = f;
    err_clear = c;
    exp_err = s | (exp_err & ~c);
    @(negedge clock);
    check("timeout_err", timeout_err, exp_err);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, slice_ready, 0);
    check({tag, "_crst"}, comp_reset_n, 0);
    check({tag, "_bn"}, comp_block_num, 0);
    check({tag, "_idx"}, comp_index, 0);
    check({tag, "_done"}, slice_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, timeout_err, 0);
  endtask
  // d*: RUN cycle index in which flush-done is pulsed; >= TO means never (timeout).
  task automatic run_slice(input logic [31:0] blk, input int d0, input int d1, input int d2,
                           input bit hold, input bit abort);
    int d[3];
    int w, run;
    logic [31:0] bn;
    d[0] = d0; d[1] = d1; d[2] = d2;
    w = 0;
    while (!slice_ready && w < 100) begin tick(0, 0, 0); w++; end
    check("ready_wait", slice_ready, 1);
    check("idle_busy", busy, 0);
    slice_valid = 1;
    slice_block_num = blk;
    tick(1'($urandom_range(0, 1)), 0, 0);
    slice_valid = hold;
    if (blk == 0) begin
      check("b0_done", slice_done, 1);
      check("b0_crst", comp_reset_n, 0);
      check("b0_busy", busy, 1);
      tick(0, 0, 0);
      check("b0_done_end", slice_done, 0);
      check("b0_ready", slice_ready, 1);
      return;
    end
    for (int p = 0; p < 3; p++) begin
      bn = p == 0 ? blk : ((blk >> CS) == 0 ? 32'd1 : blk >> CS);
      check("load_crst", comp_reset_n, 0);
      check("load_idx", 32'(comp_index), p);
      check("load_bn", comp_block_num, bn);
      check("load_done", slice_done, 0);
      check("load_busy", busy, 1);
      check("load_ready", slice_ready, 0);
      run = d[p] < TO ? d[p] + 1 : TO;
      tick(1'($urandom_range(0, 1)), 0, 0);
      for (int k = 0; k < run + DR; k++) begin
        check("pass_crst", comp_reset_n, 1);
        check("pass_idx", 32'(comp_index), p);
        check("pass_bn", comp_block_num, bn);
        check("pass_done", slice_done, 0);
        if (abort && p == 2 && k == 2) begin
          #2 reset_n = 0;
          #1 check_all_zero("async_rst");
          slice_valid = 0;
          exp_err = 0;
          for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            check("rst_no_done", slice_done, 0);
          end
          reset_n = 1;
          return;
        end
        if (k < run) tick(k == d[p], $urandom_range(0, 3) == 0, k == TO - 1 && d[p] != k);
        else tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 0);
      end
    end
    check("done_pulse", slice_done, 1);
    check("done_busy", busy, 1);
    check("done_ready", slice_ready, 0);
    check("done_crst", comp_reset_n, 0);
    tick(0, 0, 0);
    check("done_end", slice_done, 0);
    check("after_ready", slice_ready, 1);
    check("after_busy", busy, 0);
  endtask
  initial begin
    @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1;
    tick(0, 0, 0);
    check("ready_rise", slice_ready, 1);
    run_slice(4, 0, 0, 0, 0, 0);
    run_slice(1, 0, 0, 0, 0, 0);
    run_slice(0, 0, 0, 0, 0, 0);
    run_slice(8, 3, 20, 1, 0, 0);
    tick(0, 1, 0);
    check("err_cleared", timeout_err, 0);
    run_slice(5, 15, 15, 14, 0, 0);
    run_slice(6, 1, 2, 3, 1, 0);
    run_slice(3, 0, 0, 0, 0, 0);
    run_slice(7, 2, 2, 10, 0, 1);
    run_slice(9, 1, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      run_slice($urandom_range(0, 4) == 0 ? 32'd0 : $urandom_range(1, 40),
                $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                1'($urandom_range(0, 1)), 0);
    slice_valid = 0;
    tick(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
